// File: rtl/renode_inputs_arbitrated.sv
// Interrupt/GPIO input bridge: per-channel synchronise, debounce and rise/fall masking,
// with pending events serialised round-robin onto a valid/ready message port.
package renode_pkg;
    typedef logic [31:0] address_t;
    typedef logic [31:0] data_t;
endpackage

module renode_inputs_arbitrated #(
    parameter int unsigned          InputsCount    = 1,
    parameter int unsigned          SyncStages     = 2,
    parameter int unsigned          DebounceCycles = 0,
    parameter renode_pkg::address_t AddressBase    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [InputsCount-1:0] inputs,
    input  logic [InputsCount-1:0] report_rise,
    input  logic [InputsCount-1:0] report_fall,
    output logic                   msg_valid,
    input  logic                   msg_ready,
    output renode_pkg::address_t   msg_address,
    output renode_pkg::data_t      msg_data,
    output logic [InputsCount-1:0] pending,
    output logic [15:0]            coalesced_count
);
    localparam int N    = int'(InputsCount);
    localparam int IdxW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]    synced;
    logic [N-1:0]    stable;
    logic [N-1:0]    stable_next;
    logic [N-1:0]    value;
    logic [N-1:0]    report;
    logic [N-1:0]    granted;
    logic [IdxW-1:0] rr_ptr;
    logic [IdxW-1:0] grant_idx;
    logic            grant_any;
    logic            grant_val;
    logic            slot_free;
    logic [15:0]     coalesced_next;

    generate
        if (SyncStages == 0) begin : g_no_sync
            assign synced = inputs;
        end else begin : g_sync
            logic [SyncStages-1:0][N-1:0] chain;

            // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    chain <= '0;
                end else begin
                    chain[0] <= inputs;
                    for (int s = 1; s < int'(SyncStages); s++) chain[s] <= chain[s-1];
                end
            end

            assign synced = chain[SyncStages-1];
        end
    endgenerate

    generate
        if (DebounceCycles <= 1) begin : g_no_debounce
            assign stable_next = synced;
        end else begin : g_debounce
            localparam int CntW = $clog2(DebounceCycles);
            localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);
            logic [N-1:0][CntW-1:0] cnt;

            // NOTE: the default assignment before the loop keeps this block free of latches.
            always_comb begin
                stable_next = stable;
                for (int i = 0; i < N; i++)
                    if (synced[i] != stable[i] && cnt[i] == CntLast) stable_next[i] = synced[i];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt <= '0;
                end else begin
                    for (int i = 0; i < N; i++) begin
                        if (synced[i] == stable[i] || cnt[i] == CntLast) cnt[i] <= '0;
                        else                                             cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign report    = (stable_next & ~stable & report_rise) | (~stable_next & stable & report_fall);
    assign slot_free = !msg_valid || msg_ready;

    // Lowest pending index at or after rr_ptr wins: smallest rotated distance from the pointer.
    always_comb begin : arbiter
        int best_off;
        int off;
        best_off  = N;
        off       = 0;
        grant_idx = '0;
        grant_val = 1'b0;
        granted   = '0;
        for (int i = 0; i < N; i++) begin
            off = (i + N - int'(rr_ptr)) % N;
            if (slot_free && pending[i] && off < best_off) begin
                best_off  = off;
                grant_idx = IdxW'(i);
                grant_val = value[i];
            end
        end
        grant_any = (best_off < N);
        for (int i = 0; i < N; i++) granted[i] = grant_any && (grant_idx == IdxW'(i));
    end

    // A pending event overwritten before it was granted counts as coalesced.
    always_comb begin : coalesce
        int total;
        total = int'(coalesced_count);
        for (int i = 0; i < N; i++)
            if (report[i] && pending[i] && !granted[i]) total = total + 1;
        coalesced_next = (total > 65535) ? 16'hFFFF : total[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable          <= '0;
            pending         <= '0;
            value           <= '0;
            msg_valid       <= 1'b0;
            msg_address     <= '0;
            msg_data        <= '0;
            coalesced_count <= '0;
            rr_ptr          <= '0;
        end else begin
            stable          <= stable_next;
            coalesced_count <= coalesced_next;
            for (int i = 0; i < N; i++) begin
                if (report[i]) begin
                    pending[i] <= 1'b1;
                    value[i]   <= stable_next[i];
                end else if (granted[i]) begin
                    pending[i] <= 1'b0;
                end
            end
            if (slot_free) begin
                if (grant_any) begin
                    msg_valid   <= 1'b1;
                    msg_address <= AddressBase + renode_pkg::address_t'(grant_idx);
                    msg_data    <= renode_pkg::data_t'(grant_val);
                    rr_ptr      <= (grant_idx == IdxW'(N - 1)) ? '0 : grant_idx + 1'b1;
                end else begin
                    msg_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_renode_inputs_arbitrated.sv
// Self-checking bench for renode_inputs_arbitrated: directed scenarios plus a
// randomized run compared against a cycle-level behavioural model.
module tb_renode_inputs_arbitrated;
    localparam int          N       = 4;
    localparam int          S       = 2;
    localparam logic [31:0] BASE    = 32'h40;
    localparam logic [31:0] DB_BASE = 32'h80;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  inputs, report_rise, report_fall;
    logic        msg_ready;
    logic        msg_valid;
    logic [31:0] msg_address, msg_data;
    logic [3:0]  pending;
    logic [15:0] coalesced_count;

    logic [3:0]  inputs_db, rise_db, fall_db;
    logic        ready_db;
    logic        msg_valid_db;
    logic [31:0] msg_address_db, msg_data_db;
    logic [3:0]  pending_db;
    logic [15:0] coalesced_db;

    int checks = 0;
    int errors = 0;

    // Behavioural model state for the randomized run
    logic [3:0]  hist[$];
    bit          m_stable[N];
    bit          m_pending[N];
    bit          m_value[N];
    bit          m_valid;
    int          m_ch;
    bit          m_data;
    int          m_ptr;
    int          m_coal;

    renode_inputs_arbitrated #(
        .InputsCount(N), .SyncStages(S), .DebounceCycles(0), .AddressBase(BASE)
    ) dut (
        .clk(clk), .rst(rst), .inputs(inputs), .report_rise(report_rise),
        .report_fall(report_fall), .msg_valid(msg_valid), .msg_ready(msg_ready),
        .msg_address(msg_address), .msg_data(msg_data), .pending(pending),
        .coalesced_count(coalesced_count)
    );

    renode_inputs_arbitrated #(
        .InputsCount(N), .SyncStages(S), .DebounceCycles(4), .AddressBase(DB_BASE)
    ) dut_db (
        .clk(clk), .rst(rst), .inputs(inputs_db), .report_rise(rise_db),
        .report_fall(fall_db), .msg_valid(msg_valid_db), .msg_ready(ready_db),
        .msg_address(msg_address_db), .msg_data(msg_data_db), .pending(pending_db),
        .coalesced_count(coalesced_db)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; inputs = '0; inputs_db = '0; msg_ready = 1'b1; ready_db = 1'b1;
        report_rise = 4'hF; report_fall = 4'hF; rise_db = 4'hF; fall_db = 4'hF;
        repeat (3) tick();
        checks++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", msg_valid); end
        checks++; if (msg_address !== 32'h0 || msg_data !== 32'h0) begin errors++; $display("FAIL reset_msg got %h/%h exp 0/0", msg_address, msg_data); end
        checks++; if (pending !== 4'h0) begin errors++; $display("FAIL reset_pending got %h exp 0", pending); end
        checks++; if (coalesced_count !== 16'h0) begin errors++; $display("FAIL reset_coalesced got %h exp 0", coalesced_count); end
        rst = 1'b0;
        repeat (4) tick();
        checks++; if (msg_valid !== 1'b0 || msg_valid_db !== 1'b0) begin errors++; $display("FAIL idle_valid got %b/%b exp 0/0", msg_valid, msg_valid_db); end
    endtask

    task automatic test_basic_rise();
        inputs[3] = 1'b1;
        tick(); tick();
        checks++; if (pending !== 4'h0 || msg_valid !== 1'b0) begin errors++; $display("FAIL rise_early got pend %h valid %b exp 0/0", pending, msg_valid); end
        tick();
        checks++; if (pending !== 4'h8 || msg_valid !== 1'b0) begin errors++; $display("FAIL rise_pending got pend %h valid %b exp 8/0", pending, msg_valid); end
        tick();
        checks++; if (msg_valid !== 1'b1 || msg_address !== BASE + 3 || msg_data !== 32'd1) begin
            errors++; $display("FAIL rise_msg got v%b a%h d%h exp v1 a%h d1", msg_valid, msg_address, msg_data, BASE + 3); end
        checks++; if (pending !== 4'h0) begin errors++; $display("FAIL rise_cleared got %h exp 0", pending); end
        tick();
        checks++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL rise_one_cycle got %b exp 0", msg_valid); end
    endtask

    task automatic expect_sequence(input string name, input int chs[], input logic [31:0] data);
        repeat (3) tick();
        foreach (chs[k]) begin
            tick();
            checks++; if (msg_valid !== 1'b1 || msg_address !== BASE + 32'(chs[k]) || msg_data !== data) begin
                errors++; $display("FAIL %s[%0d] got v%b a%h d%h exp v1 a%h d%h", name, k, msg_valid, msg_address, msg_data, BASE + 32'(chs[k]), data); end
        end
        tick();
        checks++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL %s_end got %b exp 0", name, msg_valid); end
    endtask

    task automatic test_round_robin();
        inputs = 4'b0000;
        repeat (6) tick();
        inputs = 4'b1111;
        expect_sequence("rr_rise", '{0, 1, 2, 3}, 32'd1);
        inputs = 4'b1010;
        expect_sequence("rr_fall02", '{0, 2}, 32'd0);
        inputs = 4'b0000;
        expect_sequence("rr_wrap", '{3, 1}, 32'd0);
    endtask

    task automatic test_back_to_back_coalesce();
        msg_ready = 1'b0;
        inputs[0] = 1'b1;
        repeat (4) tick();
        checks++; if (msg_valid !== 1'b1 || msg_address !== BASE) begin errors++; $display("FAIL bp_blocker got v%b a%h exp v1 a%h", msg_valid, msg_address, BASE); end
        inputs[1] = 1'b1; repeat (3) tick();
        inputs[1] = 1'b0; repeat (3) tick();
        inputs[1] = 1'b1; repeat (3) tick();
        checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL bp_pending got %h exp 2", pending); end
        checks++; if (coalesced_count !== 16'd2) begin errors++; $display("FAIL bp_coalesced got %0d exp 2", coalesced_count); end
        checks++; if (msg_valid !== 1'b1 || msg_address !== BASE || msg_data !== 32'd1) begin
            errors++; $display("FAIL bp_hold got v%b a%h d%h exp v1 a%h d1", msg_valid, msg_address, msg_data, BASE); end
        msg_ready = 1'b1;
        tick();
        checks++; if (msg_valid !== 1'b1 || msg_address !== BASE + 1 || msg_data !== 32'd1) begin
            errors++; $display("FAIL bp_release got v%b a%h d%h exp v1 a%h d1", msg_valid, msg_address, msg_data, BASE + 1); end
        tick();
        checks++; if (msg_valid !== 1'b0 || pending !== 4'h0) begin errors++; $display("FAIL bp_single got v%b p%h exp v0 p0", msg_valid, pending); end
    endtask

    task automatic test_mask();
        int n;
        logic [31:0] last_data, last_addr;
        bit ever_pending;
        inputs = 4'b0000;
        repeat (8) tick();
        report_fall[0] = 1'b0;
        n = 0; last_data = '1; last_addr = '1;
        inputs[0] = 1'b1;
        for (int c = 0; c < 22; c++) begin
            if (c == 10) inputs[0] = 1'b0;
            tick();
            if (msg_valid) begin n++; last_data = msg_data; last_addr = msg_address; end
        end
        checks++; if (n !== 1) begin errors++; $display("FAIL mask_rise_count got %0d exp 1", n); end
        checks++; if (last_data !== 32'd1 || last_addr !== BASE) begin errors++; $display("FAIL mask_rise_msg got a%h d%h exp a%h d1", last_addr, last_data, BASE); end
        report_rise[0] = 1'b0;
        n = 0; ever_pending = 1'b0;
        inputs[0] = 1'b1;
        for (int c = 0; c < 22; c++) begin
            if (c == 10) inputs[0] = 1'b0;
            tick();
            if (msg_valid) n++;
            ever_pending |= pending[0];
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL mask_off_count got %0d exp 0", n); end
        checks++; if (ever_pending !== 1'b0) begin errors++; $display("FAIL mask_off_pending got %b exp 0", ever_pending); end
        report_rise = 4'hF; report_fall = 4'hF;
    endtask

    task automatic test_debounce();
        int n;
        int first_c;
        bit ever_pending;
        logic [31:0] a[2], d[2];
        inputs_db[1] = 1'b1;
        n = 0; ever_pending = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (c == 3) inputs_db[1] = 1'b0;
            tick();
            if (msg_valid_db) n++;
            ever_pending |= pending_db[1];
        end
        checks++; if (n !== 0 || ever_pending !== 1'b0) begin errors++; $display("FAIL db_short got msgs %0d pend %b exp 0/0", n, ever_pending); end
        checks++; if (coalesced_db !== 16'd0) begin errors++; $display("FAIL db_short_coal got %0d exp 0", coalesced_db); end
        inputs_db[1] = 1'b1;
        n = 0; first_c = -1; a = '{default: '0}; d = '{default: '0};
        for (int c = 0; c < 20; c++) begin
            if (c == 4) inputs_db[1] = 1'b0;
            tick();
            if (msg_valid_db) begin
                if (n < 2) begin a[n] = msg_address_db; d[n] = msg_data_db; end
                if (n == 0) first_c = c;
                n++;
            end
        end
        checks++; if (n !== 2) begin errors++; $display("FAIL db_count got %0d exp 2", n); end
        checks++; if (first_c !== S + 4) begin errors++; $display("FAIL db_latency got edge %0d exp %0d", first_c, S + 4); end
        checks++; if (a[0] !== DB_BASE + 1 || d[0] !== 32'd1) begin errors++; $display("FAIL db_rise got a%h d%h exp a%h d1", a[0], d[0], DB_BASE + 1); end
        checks++; if (a[1] !== DB_BASE + 1 || d[1] !== 32'd0) begin errors++; $display("FAIL db_fall got a%h d%h exp a%h d0", a[1], d[1], DB_BASE + 1); end
    endtask

    task automatic test_reset_midop();
        msg_ready = 1'b0;
        inputs = 4'b0001;
        repeat (4) tick();
        checks++; if (msg_valid !== 1'b1) begin errors++; $display("FAIL rst_pre got %b exp 1", msg_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (msg_valid !== 1'b0 || msg_address !== 32'h0 || msg_data !== 32'h0) begin
            errors++; $display("FAIL rst_async got v%b a%h d%h exp 0/0/0", msg_valid, msg_address, msg_data); end
        checks++; if (pending !== 4'h0 || coalesced_count !== 16'h0) begin errors++; $display("FAIL rst_async_state got p%h c%0d exp 0/0", pending, coalesced_count); end
        inputs = 4'b0100; report_rise = 4'b0100; report_fall = 4'b0000; msg_ready = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        checks++; if (msg_valid !== 1'b0 || pending !== 4'b0100) begin errors++; $display("FAIL rst_startup_pend got v%b p%h exp v0 p4", msg_valid, pending); end
        tick();
        checks++; if (msg_valid !== 1'b1 || msg_address !== BASE + 2 || msg_data !== 32'd1) begin
            errors++; $display("FAIL rst_startup_msg got v%b a%h d%h exp v1 a%h d1", msg_valid, msg_address, msg_data, BASE + 2); end
        report_rise = 4'hF; report_fall = 4'hF;
    endtask

    // One clock edge of the reference: stable follows inputs S edges late, then
    // the round-robin grant and event bookkeeping are applied from the rules.
    task automatic model_step(input logic [3:0] drv_in, input logic rdy);
        logic [3:0] lvl;
        bit free;
        int g;
        bit rep;
        hist.push_back(drv_in);
        lvl  = (hist.size() > S) ? hist[hist.size() - 1 - S] : 4'h0;
        free = !m_valid || rdy;
        g    = -1;
        if (free) begin
            for (int off = 0; off < N; off++) begin
                if (m_pending[(m_ptr + off) % N]) begin g = (m_ptr + off) % N; break; end
            end
            if (g >= 0) begin m_valid = 1'b1; m_ch = g; m_data = m_value[g]; m_ptr = (g + 1) % N; end
            else m_valid = 1'b0;
        end
        for (int ch = 0; ch < N; ch++) begin
            rep = (lvl[ch] != m_stable[ch]) && (lvl[ch] ? report_rise[ch] : report_fall[ch]);
            if (rep) begin
                if (m_pending[ch] && ch != g && m_coal < 65535) m_coal++;
                m_pending[ch] = 1'b1;
                m_value[ch]   = lvl[ch];
            end else if (ch == g) begin
                m_pending[ch] = 1'b0;
            end
            m_stable[ch] = lvl[ch];
        end
    endtask

    task automatic test_random();
        logic [3:0] exp_pend;
        rst = 1'b1; inputs = '0; msg_ready = 1'b0;
        report_rise = 4'($urandom_range(0, 15)) | 4'b0001;
        report_fall = 4'($urandom_range(0, 15)) | 4'b1000;
        tick();
        rst = 1'b0;
        hist.delete();
        for (int ch = 0; ch < N; ch++) begin m_stable[ch] = 0; m_pending[ch] = 0; m_value[ch] = 0; end
        m_valid = 0; m_ch = 0; m_data = 0; m_ptr = 0; m_coal = 0;
        for (int c = 0; c < 600; c++) begin
            for (int ch = 0; ch < N; ch++) if ($urandom_range(0, 5) == 0) inputs[ch] = ~inputs[ch];
            msg_ready = ($urandom_range(0, 9) < 5);
            tick();
            model_step(inputs, msg_ready);
            for (int ch = 0; ch < N; ch++) exp_pend[ch] = m_pending[ch];
            checks++; if (msg_valid !== m_valid) begin errors++; $display("FAIL rand_valid c%0d got %b exp %b", c, msg_valid, m_valid); end
            if (m_valid) begin
                checks++; if (msg_address !== BASE + 32'(m_ch) || msg_data !== 32'(m_data)) begin
                    errors++; $display("FAIL rand_msg c%0d got a%h d%h exp a%h d%h", c, msg_address, msg_data, BASE + 32'(m_ch), m_data); end
            end
            checks++; if (pending !== exp_pend) begin errors++; $display("FAIL rand_pending c%0d got %h exp %h", c, pending, exp_pend); end
            checks++; if (coalesced_count !== 16'(m_coal)) begin errors++; $display("FAIL rand_coal c%0d got %0d exp %0d", c, coalesced_count, m_coal); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_rise();
        test_round_robin();
        test_back_to_back_coalesce();
        test_mask();
        test_debounce();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
